// File: rtl/hazard_detection_unit_id.sv
// Decode-stage hazard unit: tracks destinations in flight in EX/MEM, stalls IF/ID on
// hazards the EX forwarding unit cannot cover, and steers the ID branch-operand bypass.
module hazard_detection_unit_id #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             halt,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_is_branch,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic [4:0]       id_rd,
    output logic             stall,
    output logic             id_ex_bubble,
    output logic             forward_id_a,
    output logic             forward_id_b,
    output logic [CNT_W-1:0] stall_count,
    output logic [1:0]       last_cause
);

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'b00,
        CAUSE_LOAD_USE = 2'b01,
        CAUSE_BR_ALU   = 2'b10,
        CAUSE_BR_LOAD  = 2'b11
    } cause_e;

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       ld;
    } shadow_t;

    shadow_t          ex_q, ex_d;
    shadow_t          mem_q, mem_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    cause_e           last_cause_q, last_cause_d;

    logic ma_ex, mb_ex, ma_mem, mb_mem, m_ex, m_mem;
    logic load_use, br_alu, br_load;

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        ma_ex  = id_valid & id_uses_rs & ex_q.v  & (ex_q.rd  == id_rs);
        mb_ex  = id_valid & id_uses_rt & ex_q.v  & (ex_q.rd  == id_rt);
        ma_mem = id_valid & id_uses_rs & mem_q.v & (mem_q.rd == id_rs);
        mb_mem = id_valid & id_uses_rt & mem_q.v & (mem_q.rd == id_rt);
        m_ex   = ma_ex | mb_ex;
        m_mem  = ma_mem | mb_mem;

        load_use = m_ex & ex_q.ld;
        br_alu   = id_is_branch & m_ex & ~ex_q.ld;
        br_load  = id_is_branch & m_mem & mem_q.ld;
        stall    = load_use | br_alu | br_load;

        // A MEM-stage ALU result reaches the ID comparator; any stall cause wins over it.
        forward_id_a = id_is_branch & ma_mem & ~mem_q.ld & ~stall;
        forward_id_b = id_is_branch & mb_mem & ~mem_q.ld & ~stall;
        id_ex_bubble = stall;

        ex_d          = ex_q;
        mem_d         = mem_q;
        stall_count_d = stall_count_q;
        last_cause_d  = last_cause_q;

        if (!halt) begin
            mem_d    = ex_q;
            ex_d.v   = id_valid & id_reg_write & (id_rd != 5'd0) & ~stall;
            ex_d.rd  = id_rd;
            ex_d.ld  = id_mem_read;

            if (stall && (stall_count_q != '1)) begin
                stall_count_d = stall_count_q + CNT_W'(1);
            end

            if (load_use)     last_cause_d = CAUSE_LOAD_USE;
            else if (br_alu)  last_cause_d = CAUSE_BR_ALU;
            else if (br_load) last_cause_d = CAUSE_BR_LOAD;
            else              last_cause_d = CAUSE_NONE;
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q          <= '0;
            mem_q         <= '0;
            stall_count_q <= '0;
            last_cause_q  <= CAUSE_NONE;
        end else begin
            ex_q          <= ex_d;
            mem_q         <= mem_d;
            stall_count_q <= stall_count_d;
            last_cause_q  <= last_cause_d;
        end
    end

    assign stall_count = stall_count_q;
    assign last_cause  = last_cause_q;

endmodule

// File: tb/tb_hazard_detection_unit_id.sv
// Directed bench for hazard_detection_unit_id: hand-computed expectations for each
// hazard scenario, checked with immediate assertions.
module tb_hazard_detection_unit_id;

    // A narrow counter keeps the saturation run short; all-ones is derived from the width.
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             halt;
    logic             id_valid;
    logic [4:0]       id_rs, id_rt, id_rd;
    logic             id_uses_rs, id_uses_rt, id_is_branch, id_reg_write, id_mem_read;
    logic             stall, id_ex_bubble, forward_id_a, forward_id_b;
    logic [CNT_W-1:0] stall_count;
    logic [1:0]       last_cause;

    int checks   = 0;
    int failures = 0;

    hazard_detection_unit_id #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .halt         (halt),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rs   (id_uses_rs),
        .id_uses_rt   (id_uses_rt),
        .id_is_branch (id_is_branch),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .id_rd        (id_rd),
        .stall        (stall),
        .id_ex_bubble (id_ex_bubble),
        .forward_id_a (forward_id_a),
        .forward_id_b (forward_id_b),
        .stall_count  (stall_count),
        .last_cause   (last_cause)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_out(input string tag, input logic st, input logic fa, input logic fb);
        check({tag, ".stall"},  32'(stall),        32'(st));
        check({tag, ".bubble"}, 32'(id_ex_bubble), 32'(st));
        check({tag, ".fwd_a"},  32'(forward_id_a), 32'(fa));
        check({tag, ".fwd_b"},  32'(forward_id_b), 32'(fb));
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic br,
                         input logic rw, input logic mr, input logic [4:0] rd);
        id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
        id_is_branch = br; id_reg_write = rw; id_mem_read = mr; id_rd = rd;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Instruction shapes used below.
    task automatic op_load(input logic [4:0] rd);   drive(1, 5'd29, 5'd0, 1, 0, 0, 1, 1, rd); endtask
    task automatic op_alui(input logic [4:0] rd, input logic [4:0] rs); drive(1, rs, 5'd0, 1, 0, 0, 1, 0, rd); endtask
    task automatic op_add(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        drive(1, rs, rt, 1, 1, 0, 1, 0, rd);
    endtask
    task automatic op_branch(input logic [4:0] rs, input logic [4:0] rt);
        drive(1, rs, rt, 1, 1, 1, 0, 0, 5'd0);
    endtask
    task automatic op_nop(); drive(0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 5'd0); endtask
    task automatic drain(); op_nop(); tick(); tick(); endtask

    initial begin
        rst_n = 1'b0;
        halt  = 1'b0;
        op_nop();
        #3;
        check_out("reset", 0, 0, 0);
        check("reset.count", 32'(stall_count), 32'd0);
        check("reset.cause", 32'(last_cause), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // LW $8 ; ADD $9,$8,$8 -> one load-use stall
        op_load(5'd8);           check_out("lw8", 0, 0, 0); tick();
        op_add(5'd9, 5'd8, 5'd8); check_out("lu.c0", 1, 0, 0); tick();
        check("lu.count", 32'(stall_count), 32'd1);
        check("lu.cause", 32'(last_cause), 32'd1);
        check_out("lu.c1", 0, 0, 0); tick();
        check("lu.cause_clear", 32'(last_cause), 32'd0);
        drain();

        // ADDI $5 ; BEQ $5,$6 -> one stall, then bypass on A
        op_alui(5'd5, 5'd0);      check_out("addi5", 0, 0, 0); tick();
        op_branch(5'd5, 5'd6);    check_out("bra.c0", 1, 0, 0); tick();
        check("bra.cause", 32'(last_cause), 32'd2);
        check_out("bra.c1", 0, 1, 0); tick();
        drain();

        // LW $3 ; BNE $7,$3 -> two stalls, no bypass afterwards
        op_load(5'd3);            tick();
        op_branch(5'd7, 5'd3);    check_out("brl.c0", 1, 0, 0); tick();
        check_out("brl.c1", 1, 0, 0); tick();
        check("brl.cause", 32'(last_cause), 32'd3);
        check_out("brl.c2", 0, 0, 0);
        check("brl.count", 32'(stall_count), 32'd4);
        tick();
        drain();

        // ADDI $0 ; BEQ $0,$0 -> $0 never matches
        op_alui(5'd0, 5'd1);      tick();
        op_branch(5'd0, 5'd0);    check_out("r0.c0", 0, 0, 0); tick();
        check_out("r0.c1", 0, 0, 0); tick();
        drain();

        // ADDI $4 ; ADDI $6 ; BEQ $4,$6 -> EX match stalls and masks MEM bypass, then B bypasses
        op_alui(5'd4, 5'd1);      tick();
        op_alui(5'd6, 5'd1);      tick();
        op_branch(5'd4, 5'd6);    check_out("dual.c0", 1, 0, 0); tick();
        check_out("dual.c1", 0, 0, 1); tick();
        drain();

        // Flushed ID slot behind a load neither stalls nor enters the shadow
        op_load(5'd8);            tick();
        drive(0, 5'd8, 5'd8, 1, 1, 1, 1, 1, 5'd8); check_out("flush", 0, 0, 0); tick();
        op_add(5'd9, 5'd8, 5'd8); check_out("flush.after", 0, 0, 0); tick();
        check("flush.count", 32'(stall_count), 32'd5);
        drain();

        // Load-use held under halt for 5 cycles
        op_load(5'd10);           tick();
        op_add(5'd11, 5'd10, 5'd0);
        halt = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_out("halt.hold", 1, 0, 0);
            tick();
            check("halt.count", 32'(stall_count), 32'd5);
            check("halt.cause", 32'(last_cause), 32'd0);
        end
        halt = 1'b0; #1;
        check_out("halt.release", 1, 0, 0); tick();
        check("halt.count_after", 32'(stall_count), 32'd6);
        check("halt.cause_after", 32'(last_cause), 32'd1);
        check_out("halt.done", 0, 0, 0); tick();
        drain();

        // Saturation: two stalls per three cycles, well past 2^CNT_W + 3 stall cycles
        for (int i = 0; i < (1 << CNT_W) / 2 + 4; i++) begin
            op_load(5'd1);           tick();
            op_add(5'd2, 5'd1, 5'd1); tick();
            op_branch(5'd1, 5'd0);   tick();
        end
        check("sat.count", 32'(stall_count), 32'((1 << CNT_W) - 1));

        // Async reset in the middle of a stall clears everything without a clock edge
        op_load(5'd12);           tick();
        op_add(5'd13, 5'd12, 5'd0); check_out("rst.pre", 1, 0, 0);
        rst_n = 1'b0; #1;
        check_out("rst.mid", 0, 0, 0);
        check("rst.count", 32'(stall_count), 32'd0);
        check("rst.cause", 32'(last_cause), 32'd0);
        tick();
        rst_n = 1'b1; #1;
        check_out("rst.after", 0, 0, 0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
